matmul_mult_scheduler: RTL and testbench

- Sequences one shared multi-cycle 8-bit signed multiplier (e.g. multiplier_controller) to compute C = A x B for two NxN signed matrices.
- Holds both operand matrices in internal register files and issues every product a[i][k]*b[k][j] in row-major order.
- Accumulates each dot product and streams C elements out over a valid/ready port.
- Sits between the matrix-multiplier host/load logic and the multiplier datapath.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/matmul_operand_rf.sv | 62 ++++++
 rtl/matmul_mult_scheduler.sv | 170 +++++++++++++++++
 tb/tb_matmul_mult_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply scheduler slice.
//   - default matrix dimension and operand width
//   - index / accumulator width helpers
//   - scheduler FSM state encoding
package matmul_pkg;

    localparam int DEF_N  = 2;
    localparam int DEF_DW = 8;

    // Row/column index width; a 1x1 matrix still needs a 1-bit index.
    function automatic int aw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: product width plus headroom for N additions.
    function automatic int cw_of(input int pw, input int n);
        return pw + $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/matmul_operand_rf.sv
// Operand register files for the matrix-multiply scheduler.
// Holds A and B (each N*N signed DW-bit elements, row-major), with one
// synchronous write port shared by both matrices and two asynchronous
// read ports, A[a_row][a_col] and B[b_row][b_col]. Contents are not reset.
//   clk        clock
//   wr_en_i    write strobe
//   wr_sel_i   0 = write A, 1 = write B
//   wr_addr_i  row*N+col; addresses >= N*N are dropped
//   wr_data_i  element to write
//   a_row_i/a_col_i, b_row_i/b_col_i  read coordinates
//   a_data_o, b_data_o                read data
module matmul_operand_rf
    import matmul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int AW = aw_of(N)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [2*AW-1:0]      wr_addr_i,
    input  logic signed [DW-1:0] wr_data_i,
    input  logic [AW-1:0]        a_row_i,
    input  logic [AW-1:0]        a_col_i,
    input  logic [AW-1:0]        b_row_i,
    input  logic [AW-1:0]        b_col_i,
    output logic signed [DW-1:0] a_data_o,
    output logic signed [DW-1:0] b_data_o
);

    localparam int IW = $clog2(N * N);
    // One bit wider than the address so N*N itself is representable.
    localparam logic [2*AW:0] NUM_EL = (2*AW+1)'(N * N);

    logic signed [DW-1:0] a_mem_q [N*N];
    logic signed [DW-1:0] b_mem_q [N*N];

    logic          in_range;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] b_idx;

    assign in_range = ({1'b0, wr_addr_i} < NUM_EL);
    assign wr_idx   = wr_addr_i[IW-1:0];
    assign a_idx    = IW'(int'(a_row_i) * N + int'(a_col_i));
    assign b_idx    = IW'(int'(b_row_i) * N + int'(b_col_i));

    always_ff @(posedge clk) begin
        if (wr_en_i && in_range) begin
            if (wr_sel_i) begin
                b_mem_q[wr_idx] <= wr_data_i;
            end else begin
                a_mem_q[wr_idx] <= wr_data_i;
            end
        end
    end

    assign a_data_o = a_mem_q[a_idx];
    assign b_data_o = b_mem_q[b_idx];

endmodule

// File: rtl/matmul_mult_scheduler.sv
// Matrix-multiply scheduler: computes C = A x B for NxN signed matrices
// using one shared multi-cycle multiplier. Products a[i][k]*b[k][j] are
// issued in row-major order, summed per dot product, and each C element
// is streamed out over a valid/ready port.
//   clk, rst                 clock; asynchronous active-low reset
//   ld_en/ld_sel/ld_addr/ld_data   operand load port (IDLE only)
//   start                    begin a computation (IDLE only)
//   busy, done               status; done pulses once after the last element
//   mul_start/mul_a/mul_b    multiply request; operands held until mul_done
//   mul_done/mul_q           multiplier result (valid with mul_done)
//   out_valid/out_ready      C element handshake
//   out_data/out_row/out_col C[i][j] and its coordinates
module matmul_mult_scheduler
    import matmul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int PW = 2 * DW,
    parameter int AW = aw_of(N),
    parameter int CW = cw_of(PW, N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [2*AW-1:0]      ld_addr,
    input  logic signed [DW-1:0] ld_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mul_start,
    output logic signed [DW-1:0] mul_a,
    output logic signed [DW-1:0] mul_b,
    input  logic                 mul_done,
    input  logic signed [PW-1:0] mul_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW-1:0] out_data,
    output logic [AW-1:0]        out_row,
    output logic [AW-1:0]        out_col
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        i_q, i_d;
    logic [AW-1:0]        j_q, j_d;
    logic [AW-1:0]        k_q, k_d;
    logic signed [CW-1:0] acc_q, acc_d;
    logic                 done_q, done_d;

    logic                 rf_we;
    logic signed [DW-1:0] rf_a;
    logic signed [DW-1:0] rf_b;
    logic signed [CW-1:0] prod_ext;
    logic                 mul_phase;

    // Loads are only honoured while idle so a running computation always
    // sees a consistent pair of matrices.
    assign rf_we = ld_en && (state_q == S_IDLE);

    matmul_operand_rf #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_rf (
        .clk       (clk),
        .wr_en_i   (rf_we),
        .wr_sel_i  (ld_sel),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .a_row_i   (i_q),
        .a_col_i   (k_q),
        .b_row_i   (k_q),
        .b_col_i   (j_q),
        .a_data_o  (rf_a),
        .b_data_o  (rf_b)
    );

    assign prod_ext = {{(CW-PW){mul_q[PW-1]}}, mul_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    acc_d = acc_q + prod_ext;
                    if (k_q == LAST) begin
                        state_d = S_OUT;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + AW'(1);
                    end else begin
                        j_d = j_q + AW'(1);
                    end
                    if ((i_q == LAST) && (j_q == LAST)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operands are gated to zero outside a multiply so they read as zero
    // in reset and idle rather than showing stale register-file contents;
    // i and k do not move between ISSUE and mul_done, so they stay stable.
    assign mul_phase = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign mul_start = (state_q == S_ISSUE);
    assign mul_a     = mul_phase ? rf_a : '0;
    assign mul_b     = mul_phase ? rf_b : '0;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_row   = out_valid ? i_q : '0;
    assign out_col   = out_valid ? j_q : '0;

endmodule

// File: tb/tb_matmul_mult_scheduler.sv
module tb_matmul_mult_scheduler;

    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // N = 2 instance
    logic               ld_en = 1'b0, ld_sel = 1'b0, start = 1'b0;
    logic [1:0]         ld_addr = '0;
    logic signed [7:0]  ld_data = '0;
    logic               busy, done, mul_start, mul_done, out_valid;
    logic               out_ready = 1'b1;
    logic signed [7:0]  mul_a, mul_b;
    logic signed [15:0] mul_q;
    logic signed [16:0] out_data;
    logic [0:0]         out_row, out_col;
    logic               stray = 1'b0;

    // N = 3 instance
    logic               ld_en3 = 1'b0, ld_sel3 = 1'b0, start3 = 1'b0;
    logic [3:0]         ld_addr3 = '0;
    logic signed [7:0]  ld_data3 = '0;
    logic               busy3, done3, mul_start3, mul_done3, out_valid3;
    logic               out_ready3 = 1'b1;
    logic signed [7:0]  mul_a3, mul_b3;
    logic signed [15:0] mul_q3;
    logic signed [17:0] out_data3;
    logic [1:0]         out_row3, out_col3;

    matmul_mult_scheduler #(.N(2), .DW(8)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .busy(busy), .done(done),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
        .mul_q(mul_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col)
    );

    matmul_mult_scheduler #(.N(3), .DW(8)) dut3 (
        .clk(clk), .rst(rst), .ld_en(ld_en3), .ld_sel(ld_sel3), .ld_addr(ld_addr3),
        .ld_data(ld_data3), .start(start3), .busy(busy3), .done(done3),
        .mul_start(mul_start3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_done(mul_done3),
        .mul_q(mul_q3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_row(out_row3), .out_col(out_col3)
    );

    // Fixed-latency multiplier models: mul_done L cycles after mul_start.
    int mcnt = 0, mcnt3 = 0;
    logic signed [15:0] ma = '0, mb = '0, ma3 = '0, mb3 = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            ma <= {{8{mul_a[7]}}, mul_a};
            mb <= {{8{mul_b[7]}}, mul_b};
            mcnt <= 1;
        end else if (mcnt == L) mcnt <= 0;
        else if (mcnt != 0) mcnt <= mcnt + 1;
    end
    assign mul_done = (mcnt == L) || stray;
    assign mul_q    = ma * mb;

    always @(posedge clk) begin
        if (mul_start3) begin
            ma3 <= {{8{mul_a3[7]}}, mul_a3};
            mb3 <= {{8{mul_b3[7]}}, mul_b3};
            mcnt3 <= 1;
        end else if (mcnt3 == L) mcnt3 <= 0;
        else if (mcnt3 != 0) mcnt3 <= mcnt3 + 1;
    end
    assign mul_done3 = (mcnt3 == L);
    assign mul_q3    = ma3 * mb3;

    int n_assert = 0, n_fail = 0;

    int A_BASIC[4]   = '{-7, 2, 3, 4};
    int B_BASIC[4]   = '{-7, 1, 0, -1};
    int A_MIN[4]     = '{-128, -128, -128, -128};
    int EXP_BASIC[4] = '{49, -9, -21, -1};
    int EXP_MIN[4]   = '{32768, 32768, 32768, 32768};
    int EXP_LDST[4]  = '{56, -10, -21, -1};

    int got_d[16], got_r[16], got_c[16];
    int n_got, n_done, n_mstart, stab_err, done_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr2(input bit sel, input int addr, input int val);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr[1:0]; ld_data = val[7:0];
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wr3(input bit sel, input int addr, input int val);
        ld_en3 = 1'b1; ld_sel3 = sel; ld_addr3 = addr[3:0]; ld_data3 = val[7:0];
        tick();
        ld_en3 = 1'b0;
    endtask

    task automatic load2(input int a[4], input int b[4]);
        for (int e = 0; e < 4; e++) wr2(1'b0, e, a[e]);
        for (int e = 0; e < 4; e++) wr2(1'b1, e, b[e]);
    endtask

    task automatic clear_got();
        for (int e = 0; e < 16; e++) begin
            got_d[e] = -999999; got_r[e] = -1; got_c[e] = -1;
        end
        n_got = 0; n_done = 0; n_mstart = 0; stab_err = 0; done_cyc = -1;
    endtask

    // Run one computation on the N=2 instance. bp = cycles out_ready is held
    // low per element; poke = mid-run start/ld_en/stray mul_done; ld_start =
    // write A[0][0] = -8 in the same cycle as start.
    task automatic run2(input int bp, input bit poke, input bit ld_start);
        int hold, cap_d, cap_r, cap_c;
        hold = 0; cap_d = 0; cap_r = 0; cap_c = 0;
        clear_got();
        out_ready = 1'b1;
        start = 1'b1;
        if (ld_start) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd0; ld_data = -8'sd8;
        end
        tick();
        start = 1'b0; ld_en = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            stray = 1'b0; start = 1'b0; ld_en = 1'b0;
            if (mul_start) n_mstart++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (poke && cyc == 10) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd0; ld_data = 8'sd99;
            end
            if (poke && cyc == 11) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 2'd3; ld_data = -8'sd50;
            end
            if (out_valid) begin
                if (hold == 0) begin
                    cap_d = int'(out_data); cap_r = int'(out_row); cap_c = int'(out_col);
                    if (poke && n_got == 1) stray = 1'b1;
                end else if (int'(out_data) != cap_d || int'(out_row) != cap_r
                             || int'(out_col) != cap_c || mul_start) begin
                    stab_err++;
                end
                if (hold < bp) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                    if (n_got < 16) begin
                        got_d[n_got] = int'(out_data);
                        got_r[n_got] = int'(out_row);
                        got_c[n_got] = int'(out_col);
                    end
                    n_got++;
                    hold = 0;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 4) break;
            tick();
        end
        out_ready = 1'b1; stray = 1'b0; start = 1'b0; ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_assert++;
        if ({busy, done, mul_start, mul_a, mul_b, out_valid, out_data, out_row, out_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_n2: got busy=%b done=%b ms=%b a=%0d b=%0d v=%b d=%0d r=%0d c=%0d, expected all 0",
                     busy, done, mul_start, mul_a, mul_b, out_valid, out_data, out_row, out_col);
        end
        n_assert++;
        if ({busy3, done3, mul_start3, mul_a3, mul_b3, out_valid3, out_data3, out_row3, out_col3} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_n3: got busy=%b valid=%b data=%0d, expected all 0",
                     busy3, out_valid3, out_data3);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load2(A_BASIC, B_BASIC);
        run2(0, 1'b0, 1'b0);
        n_assert++;
        if (n_got !== 4) begin
            n_fail++; $display("FAIL basic_count: got %0d elements, expected 4", n_got);
        end
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_BASIC[e] || got_r[e] !== e / 2 || got_c[e] !== e % 2) begin
                n_fail++;
                $display("FAIL basic_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 2, e % 2, EXP_BASIC[e]);
            end
        end
        n_assert++;
        if (done_cyc !== 45) begin
            n_fail++; $display("FAIL basic_done_latency: got %0d, expected 45", done_cyc);
        end
        n_assert++;
        if (n_done !== 1 || n_mstart !== 8) begin
            n_fail++;
            $display("FAIL basic_pulses: got done=%0d mul_start=%0d, expected done=1 mul_start=8", n_done, n_mstart);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle_after: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_extreme();
        load2(A_MIN, A_MIN);
        run2(0, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_MIN[e] || got_r[e] !== e / 2 || got_c[e] !== e % 2) begin
                n_fail++;
                $display("FAIL extreme_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 2, e % 2, EXP_MIN[e]);
            end
        end
    endtask

    task automatic test_backpressure();
        load2(A_BASIC, B_BASIC);
        run2(7, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_BASIC[e] || got_r[e] !== e / 2 || got_c[e] !== e % 2) begin
                n_fail++;
                $display("FAIL bp_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 2, e % 2, EXP_BASIC[e]);
            end
        end
        n_assert++;
        if (stab_err !== 0) begin
            n_fail++; $display("FAIL bp_stability: got %0d unstable cycles, expected 0", stab_err);
        end
        n_assert++;
        if (n_mstart !== 8) begin
            n_fail++; $display("FAIL bp_mul_start: got %0d, expected 8", n_mstart);
        end
        n_assert++;
        if (done_cyc !== 73) begin
            n_fail++; $display("FAIL bp_done_latency: got %0d, expected 73", done_cyc);
        end
    endtask

    task automatic test_mid_run_pokes();
        load2(A_BASIC, B_BASIC);
        run2(2, 1'b1, 1'b0);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_BASIC[e] || got_r[e] !== e / 2 || got_c[e] !== e % 2) begin
                n_fail++;
                $display("FAIL poke_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 2, e % 2, EXP_BASIC[e]);
            end
        end
        n_assert++;
        if (n_done !== 1 || n_mstart !== 8 || done_cyc !== 53) begin
            n_fail++;
            $display("FAIL poke_control: got done=%0d mul_start=%0d done_cyc=%0d, expected 1 8 53",
                     n_done, n_mstart, done_cyc);
        end
        // A second run with no reload shows the blocked writes never landed.
        run2(0, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_BASIC[e]) begin
                n_fail++;
                $display("FAIL poke_rf_elem%0d: got %0d, expected %0d", e, got_d[e], EXP_BASIC[e]);
            end
        end
    endtask

    task automatic test_load_with_start();
        load2(A_BASIC, B_BASIC);
        run2(0, 1'b0, 1'b1);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_LDST[e]) begin
                n_fail++;
                $display("FAIL ldstart_elem%0d: got %0d, expected %0d", e, got_d[e], EXP_LDST[e]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int bad;
        seen = 1'b0; bad = 0;
        load2(A_BASIC, B_BASIC);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (mul_start) seen = 1'b1;
            tick();
        end
        n_assert++;
        if (!seen) begin
            n_fail++; $display("FAIL rstwait_issue: got no mul_start within 10 cycles, expected one");
        end
        #2 rst = 1'b0;
        #1;
        n_assert++;
        if ({busy, done, mul_start, mul_a, mul_b, out_valid, out_data, out_row, out_col} !== '0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: got busy=%b ms=%b a=%0d b=%0d v=%b d=%0d, expected all 0",
                     busy, mul_start, mul_a, mul_b, out_valid, out_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy || out_valid || mul_start || done) bad++;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rstwait_quiet: got %0d active cycles after reset, expected 0", bad);
        end
        load2(A_BASIC, B_BASIC);
        run2(0, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            n_assert++;
            if (got_d[e] !== EXP_BASIC[e] || got_r[e] !== e / 2 || got_c[e] !== e % 2) begin
                n_fail++;
                $display("FAIL rstwait_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 2, e % 2, EXP_BASIC[e]);
            end
        end
        n_assert++;
        if (done_cyc !== 45) begin
            n_fail++; $display("FAIL rstwait_done_latency: got %0d, expected 45", done_cyc);
        end
    endtask

    // N=3: A = identity, B = 1..9, then out-of-range writes to 9 and 15.
    task automatic test_out_of_range();
        for (int e = 0; e < 9; e++) wr3(1'b0, e, (e % 4 == 0) ? 1 : 0);
        for (int e = 0; e < 9; e++) wr3(1'b1, e, e + 1);
        wr3(1'b0, 9, 100);
        wr3(1'b1, 15, -100);
        wr3(1'b0, 12, 55);
        clear_got();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (done3 && done_cyc < 0) done_cyc = cyc;
            if (out_valid3 && n_got < 16) begin
                got_d[n_got] = int'(out_data3);
                got_r[n_got] = int'(out_row3);
                got_c[n_got] = int'(out_col3);
                n_got++;
            end
            if (done_cyc > 0) break;
            tick();
        end
        for (int e = 0; e < 9; e++) begin
            n_assert++;
            if (got_d[e] !== e + 1 || got_r[e] !== e / 3 || got_c[e] !== e % 3) begin
                n_fail++;
                $display("FAIL oor_elem%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                         e, got_r[e], got_c[e], got_d[e], e / 3, e % 3, e + 1);
            end
        end
        n_assert++;
        if (done_cyc !== 145) begin
            n_fail++; $display("FAIL oor_done_latency: got %0d, expected 145", done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_backpressure();
        test_mid_run_pokes();
        test_load_with_start();
        test_reset_mid_wait();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
